// File: rtl/comp_share_pkg.sv
// Shared encodings for the lab resource arbiter: FSM states, 7-segment patterns
// and the round-robin winner search.
package comp_share_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Segment order {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;

    // First set bit after 'last', wrapping within n requesters; returns last if none.
    function automatic logic [2:0] rr_pick(input logic [7:0] reqv, input logic [2:0] last,
                                           input int n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            idx = int'(last) + k;
            if (idx >= n) idx = idx - n;
            if (k <= n && !found && reqv[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/comp_seg7_dec.sv
// Purpose: 3-bit value to 7-segment pattern for the lab panel display.
// Latency: combinational; the parent registers the result.
// Backpressure: none, pure decode.
module comp_seg7_dec
    import comp_share_pkg::*;
(
    input  logic [2:0] val,
    output logic [6:0] segs
);

    always_comb begin
        segs = SEG_0;
        case (val)
            3'd0: segs = SEG_0;
            3'd1: segs = SEG_1;
            3'd2: segs = SEG_2;
            3'd3: segs = SEG_3;
            3'd4: segs = SEG_4;
            3'd5: segs = SEG_5;
            3'd6: segs = SEG_6;
            3'd7: segs = SEG_7;
            default: segs = SEG_0;
        endcase
    end

endmodule

// File: rtl/comp_share_arbiter.sv
// Purpose: round-robin owner of one shared resource among N_COMPS computers, quantum-bounded.
// Latency: 1 cycle req->grant; one idle gap cycle between successive owners.
// Backpressure: requests are levels, not latched; a contended owner is preempted after MAX_HOLD.
module comp_share_arbiter
    import comp_share_pkg::*;
#(
    parameter int N_COMPS  = 5,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_COMPS-1:0] req,
    output logic [N_COMPS-1:0] grant,
    output logic               busy,
    output logic [2:0]         pend_cnt,
    output logic [6:0]         segs
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]         state, state_n;
    logic [N_COMPS-1:0] grant_n;
    logic [2:0]         last, last_n;
    logic [HOLD_W-1:0]  hold, hold_n;
    logic [2:0]         pick;
    logic [2:0]         pend_n;
    logic [2:0]         seg_val_n;
    logic [6:0]         segs_n;

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        hold_n  = hold;
        pick    = rr_pick(8'(req), last, N_COMPS);
        case (state)
            ST_GRANT: begin
                // Voluntary release is checked first so it wins over preemption
                if ((req & grant) == '0) begin
                    grant_n = '0;
                    hold_n  = '0;
                    state_n = ST_GAP;
                end else if (hold == HOLD_LAST) begin
                    hold_n = '0;
                    if ((req & ~grant) != '0) begin
                        grant_n = '0;
                        state_n = ST_GAP;
                    end
                end else begin
                    hold_n = hold + HOLD_W'(1);
                end
            end
            default: begin
                if (req != '0) begin
                    grant_n = N_COMPS'(1) << pick;
                    last_n  = pick;
                    hold_n  = '0;
                    state_n = ST_GRANT;
                end else begin
                    grant_n = '0;
                    state_n = ST_IDLE;
                end
            end
        endcase
    end

    // Pending count is taken against the grant being registered, so it lines up with it
    always_comb begin
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_COMPS; i++) begin
            cnt = cnt + 4'(req[i] & ~grant_n[i]);
        end
        pend_n = (cnt > 4'd7) ? 3'd7 : cnt[2:0];
    end

    assign seg_val_n = (grant_n != '0) ? last_n + 3'd1 : 3'd0;

    comp_seg7_dec u_seg (
        .val  (seg_val_n),
        .segs (segs_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            pend_cnt <= 3'd0;
            hold     <= '0;
            last     <= 3'(N_COMPS - 1);
            segs     <= SEG_0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            busy     <= (grant_n != '0);
            pend_cnt <= pend_n;
            hold     <= hold_n;
            last     <= last_n;
            segs     <= segs_n;
        end
    end

endmodule

// File: tb/tb_comp_share_arbiter.sv
// Randomized and directed bench for comp_share_arbiter; expectations come from an
// owner/quantum model and are compared by a separate monitor each cycle.
module tb_comp_share_arbiter;

    localparam int N        = 5;
    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic [4:0] grant;
        logic       busy;
        logic [2:0] pend;
        logic [6:0] segs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] grant;
    logic       busy;
    logic [2:0] pend_cnt;
    logic [6:0] segs;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic [6:0] seg_tab [0:7];

    // Model state: current owner (-1 none), last granted computer, cycles into quantum
    int owner;
    int last;
    int qcnt;

    comp_share_arbiter #(.N_COMPS(N), .MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .segs     (segs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = N - 1;
        qcnt  = 0;
    endtask

    task automatic model_step(input logic [4:0] r);
        logic [4:0] mine;
        bit         found;
        int         c;
        if (owner >= 0) begin
            mine = 5'b00001 << owner;
            if (r[owner] == 1'b0) begin
                owner = -1;
            end else if (qcnt == MAX_HOLD - 1) begin
                qcnt = 0;
                if ((r & ~mine) != 5'b0) owner = -1;
            end else begin
                qcnt++;
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (last + k) % N;
                if (!found && r[c]) begin
                    found = 1'b1;
                    owner = c;
                    last  = c;
                    qcnt  = 0;
                end
            end
        end
    endtask

    function automatic exp_t model_out(input logic [4:0] r);
        exp_t e;
        e.grant = (owner >= 0) ? (5'b00001 << owner) : 5'b0;
        e.busy  = (owner >= 0);
        e.pend  = 3'($countones(r & ~e.grant));
        e.segs  = seg_tab[owner + 1];
        return e;
    endfunction

    // One cycle of stimulus: drive at negedge, push what the next posedge must produce
    task automatic step(input logic [4:0] r, input logic rst_v);
        exp_t e;
        @(negedge clk);
        rst = rst_v;
        req = r;
        if (rst_v) begin
            #1;
            chk("async_rst_grant", int'(grant), 0);
            chk("async_rst_busy", int'(busy), 0);
            chk("async_rst_pend", int'(pend_cnt), 0);
            chk("async_rst_segs", int'(segs), int'(7'b1111110));
            model_reset();
            e = '{grant: 5'b0, busy: 1'b0, pend: 3'd0, segs: 7'b1111110};
        end else begin
            model_step(r);
            e = model_out(r);
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("grant", int'(grant), int'(e.grant));
                chk("busy", int'(busy), int'(e.busy));
                chk("pend_cnt", int'(pend_cnt), int'(e.pend));
                chk("segs", int'(segs), int'(e.segs));
            end
        end
    end

    initial begin : stim
        logic [4:0] r;
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000;
        seg_tab[2] = 7'b1101101; seg_tab[3] = 7'b1111001;
        seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000;
        model_reset();

        step(5'b00000, 1'b1);
        step(5'b00000, 1'b1);

        // Single requester for 4 cycles, then release, gap, idle
        repeat (4) step(5'b00100, 1'b0);
        repeat (4) step(5'b00000, 1'b0);

        // Everyone requesting: rotating quanta with gaps
        repeat (50) step(5'b11111, 1'b0);
        repeat (3) step(5'b00000, 1'b0);

        // Sole requester keeps the grant across quantum expiry
        repeat (20) step(5'b00010, 1'b0);
        repeat (2) step(5'b00000, 1'b0);

        // Owner 5 releases while 1 and 2 request: wrap to computer 1
        repeat (3) step(5'b10000, 1'b0);
        repeat (6) step(5'b00011, 1'b0);
        repeat (2) step(5'b00000, 1'b0);

        // Owner 1 near expiry drops its request as computer 2 arrives
        step(5'b00000, 1'b1);
        step(5'b00000, 1'b0);
        repeat (8) step(5'b00001, 1'b0);
        repeat (4) step(5'b00010, 1'b0);
        repeat (2) step(5'b00000, 1'b0);

        // Randomized traffic with sticky request patterns and a mid-run reset
        r = 5'($urandom_range(0, 31));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) r = 5'($urandom_range(0, 31));
            step(r, (i == 150) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
